// File: rtl/mem_image_loader_pkg.sv
// Shared types and constants for the memory image loader.
package mem_image_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // Width of the big-endian word-count header.
  localparam int LEN_WIDTH = 16;

  // MARS default segment bases (byte addresses).
  localparam logic [31:0] MARS_TEXT_BASE = 32'h00400000;
  localparam logic [31:0] MARS_DATA_BASE = 32'h10010000;

endpackage

// File: rtl/mem_image_loader_byte_word_packer.sv
// Packs a byte stream big-endian into 32-bit words. word_ready strobes
// combinationally alongside the byte that completes a word.
module mem_image_loader_byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  // Shift accepted bytes in from the low end so the first byte lands in 31:24.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_en) begin
      word     <= {word[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_ready = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/mem_image_loader.sv
// Loads a length-prefixed byte image into memory as full-word writes while
// holding the processor in reset.
// Optional trailing XOR checksum byte: define MEM_IMAGE_LOADER_CHECKSUM_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_LEN_HI  | receiving word count bits 15:8
// ST_LEN_LO  | receiving word count bits 7:0, range-checking the count
// ST_COLLECT | assembling the next data word from four bytes
// ST_WRITE   | single-cycle full-word memory write
// ST_CHK     | receiving and comparing the checksum byte (feature only)
// ST_DONE    | one cycle: flag success, release processor
// ST_ERROR   | one cycle: flag abort, keep processor held
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 30,
  parameter logic [31:0] BASE_ADDR  = MARS_TEXT_BASE,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_ce,
  output logic [3:0]            mem_wbe,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_out,
  output logic                  cpu_rst_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHK;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] n_words;
  logic [LEN_WIDTH-1:0] len_rx;
  logic [LEN_WIDTH-1:0] idx_next;
  logic [IDX_W-1:0]     word_idx;
  logic                 xfer;
  logic                 pack_en;
  logic                 word_ready;
  logic [31:0]          pack_word;
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign xfer     = byte_valid && byte_ready;
  assign pack_en  = xfer && (state == ST_COLLECT);
  assign len_rx   = {n_words[LEN_WIDTH-1:8], byte_in};
  assign idx_next = LEN_WIDTH'(word_idx) + LEN_WIDTH'(1);

  mem_image_loader_byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_IDLE),
    .byte_en    (pack_en),
    .byte_in    (byte_in),
    .word       (pack_word),
    .word_ready (word_ready)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-state handshake/write strobes.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_ce     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_rx == '0)                          state_nxt = ST_AFTER_DATA;
          else if (len_rx > LEN_WIDTH'(MAX_WORDS))   state_nxt = ST_ERROR;
          else                                       state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        if (word_ready) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_ce    = 1'b1;
        state_nxt = (idx_next == n_words) ? ST_AFTER_DATA : ST_COLLECT;
      end
      ST_CHK: begin
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = (byte_in == csum) ? ST_DONE : ST_ERROR;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE, ST_ERROR: state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // Load bookkeeping: header capture, word index, checksum and status levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words      <= '0;
      word_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst_hold <= 1'b1;
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          busy         <= 1'b1;
          cpu_rst_hold <= 1'b1;
          done         <= 1'b0;
          error        <= 1'b0;
          word_idx     <= '0;
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
          csum         <= 8'd0;
`endif
        end
        ST_LEN_HI: if (xfer) n_words[LEN_WIDTH-1:8] <= byte_in;
        ST_LEN_LO: if (xfer) n_words[7:0] <= byte_in;
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
        ST_COLLECT: if (xfer) csum <= csum ^ byte_in;
`endif
        ST_WRITE: word_idx <= word_idx + IDX_W'(1);
        ST_DONE: begin
          busy         <= 1'b0;
          done         <= 1'b1;
          cpu_rst_hold <= 1'b0;
        end
        ST_ERROR: begin
          busy         <= 1'b0;
          error        <= 1'b1;
          cpu_rst_hold <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_wbe      = {4{mem_ce}};
  assign mem_address  = ADDR_WIDTH'(BASE_ADDR[31:2]) + ADDR_WIDTH'(word_idx);
  assign mem_data_out = pack_word;

endmodule
